truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: cycles each input row is held before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a full 8-row scan; sampled only in IDLE.
REQ-005 x, y, z  output  1 each  row stimulus driven to the functions under test; x = MSB, z = LSB of the row index.
REQ-006 s1  input  1  output of the first implementation (e.g. SoP form).
REQ-007 s2  input  1  output of the second implementation (e.g. PoS form).
REQ-008 busy  output  1  high while in SETTLE or SAMPLE.
REQ-009 done  output  1  one-cycle pulse when a scan completes.
REQ-010 minterms  output  8  bit i = s1 sampled at row i.
REQ-011 maxterms  output  8  bit i = NOT s1 sampled at row i.
REQ-012 mismatch  output  8  bit i = s1 XOR s2 sampled at row i.
REQ-013 ones  output  4  population count of minterms, 0..8.
REQ-014 equal  output  1  high when mismatch == 0 after a completed scan.

Function
REQ-015 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE with start=1: row index <= 0, {x,y,z} <= 000, clear minterms/maxterms/mismatch/ones/equal, settle counter <= SETTLE_CYCLES-1, next state SETTLE.
REQ-017 SETTLE: decrement settle counter; go to SAMPLE on the edge where the counter is 0; {x,y,z} stays stable.
REQ-018 SAMPLE lasts one cycle; on its exit edge, write bit[row] of minterms, maxterms and mismatch from s1/s2.
REQ-019 SAMPLE with row < 7: row <= row+1, {x,y,z} <= row+1, reload settle counter, next state SETTLE.
REQ-020 SAMPLE with row == 7: next state DONE; no wrap to row 0.
REQ-021 Each row occupies SETTLE_CYCLES+1 cycles. DONE is entered on edge 8*(SETTLE_CYCLES+1) after the start edge (edge 16 for the default).
REQ-022 DONE lasts one cycle: done=1, ones and equal valid; next state IDLE.
REQ-023 minterms, maxterms, mismatch, ones and equal hold their values in IDLE until the next accepted start.
REQ-024 start while busy or in DONE is ignored: no restart and no timing change.
REQ-025 Only rows already sampled may have set bits during a scan; unsampled bits read 0 in all three masks.
REQ-026 ones and equal are registered from the completed masks and are valid from DONE onward; both are 0 while busy.
REQ-027 {x,y,z} returns to 000 in IDLE after DONE.

Reset
REQ-028 reset=1 forces IDLE immediately, regardless of clk, including mid-scan.
REQ-029 While reset=1, every output is 0: x, y, z, busy, done, minterms, maxterms, mismatch, ones, equal. Row index and settle counter are also 0.
REQ-030 The first accepted start after reset release produces a full scan from row 0.

Structure
REQ-031 A shared package defines the state encoding, N_INPUTS=3, N_ROWS=8 and the SETTLE_CYCLES default.
REQ-032 One sub-module, popcount8 (8-bit in, 4-bit out, combinational), computes ones.
REQ-033 The design stays within 120-400 RTL lines and has no latches.

Verification
REQ-034 s1 = SoP minterms(0,1,3,6,7), s2 = PoS maxterms(2,4,5), pulse start -> at DONE (edge 16): minterms=8'b11001011, maxterms=8'b00110100, mismatch=0, ones=5, equal=1.
REQ-035 Same as REQ-034 with s2 forced inverted at row 5 -> mismatch=8'b00100000, equal=0, minterms unchanged.
REQ-036 s1 tied to 0, SETTLE_CYCLES=3 -> minterms=0, maxterms=8'hFF, ones=0; done exactly at edge 32; {x,y,z} steps 000..111, 4 cycles per row.
REQ-037 Assert reset while row 3 is settling -> all outputs 0 immediately; after release, a new start gives a full, correct scan.
REQ-038 Re-pulse start at rows 2 and 7 during a scan -> ignored; done still at edge 16; exactly one done pulse.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM encoding and table geometry.
package truth_table_scanner_pkg;

   localparam int N_INPUTS              = 3;
   localparam int N_ROWS                = 8;
   localparam int SETTLE_CYCLES_DEFAULT = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/truth_table_scanner_popcount8.sv
// Combinational population count of an 8-bit mask (result 0..8).
module popcount8 (
   input  logic [7:0] bits,
   output logic [3:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < 8; i++) begin
         count = count + {3'b000, bits[i]};
      end
   end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks {x,y,z} through all 8 rows, samples two implementations of a function
// and records minterms, maxterms and per-row disagreement.
//
// state  | meaning
// IDLE   | waiting for start; result registers hold the last scan
// SETTLE | row stimulus applied, counting down SETTLE_CYCLES
// SAMPLE | one cycle; s1/s2 captured into bit[row] on exit
// DONE   | one-cycle done pulse; ones/equal valid
module truth_table_scanner
   import truth_table_scanner_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT   // legal range 1..15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       x,
   output logic       y,
   output logic       z,
   input  logic       s1,
   input  logic       s2,
   output logic       busy,
   output logic       done,
   output logic [7:0] minterms,
   output logic [7:0] maxterms,
   output logic [7:0] mismatch,
   output logic [3:0] ones,
   output logic       equal
);

   localparam logic [3:0]          SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [N_INPUTS-1:0] LAST_ROW    = N_INPUTS'(N_ROWS - 1);

   state_t              state, state_nxt;
   logic [N_INPUTS-1:0] row;
   logic [3:0]          settle_cnt;
   logic [7:0]          minterms_nxt, maxterms_nxt, mismatch_nxt;
   logic [3:0]          ones_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_SETTLE;
         ST_SETTLE: if (settle_cnt == 4'd0) state_nxt = ST_SAMPLE;
         ST_SAMPLE: state_nxt = (row == LAST_ROW) ? ST_DONE : ST_SETTLE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
   assign done = (state == ST_DONE);
   assign {x, y, z} = row;

   // Masks as they will be after this edge; lets ones/equal be registered
   // on the same edge that writes the final row.
   always_comb begin
      minterms_nxt = minterms;
      maxterms_nxt = maxterms;
      mismatch_nxt = mismatch;
      if (state == ST_SAMPLE) begin
         minterms_nxt[row] = s1;
         maxterms_nxt[row] = ~s1;
         mismatch_nxt[row] = s1 ^ s2;
      end
   end

   popcount8 u_popcount8 (
      .bits  (minterms_nxt),
      .count (ones_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row        <= '0;
         settle_cnt <= '0;
         minterms   <= '0;
         maxterms   <= '0;
         mismatch   <= '0;
         ones       <= '0;
         equal      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  row        <= '0;
                  settle_cnt <= SETTLE_LOAD;
                  minterms   <= '0;
                  maxterms   <= '0;
                  mismatch   <= '0;
                  ones       <= '0;
                  equal      <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
            end
            ST_SAMPLE: begin
               minterms <= minterms_nxt;
               maxterms <= maxterms_nxt;
               mismatch <= mismatch_nxt;
               if (row == LAST_ROW) begin
                  ones  <= ones_nxt;
                  equal <= (mismatch_nxt == 8'h00);
               end else begin
                  row        <= row + 1'b1;
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            ST_DONE: begin
               row <= '0;
            end
            default: begin
               row <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: default-settle instance driven by
// table-defined functions, plus a SETTLE_CYCLES=3 instance with s1 tied low.
module tb_truth_table_scanner;

   logic       clk = 1'b0;
   logic       reset;
   int         cyc = 0;

   logic       start0, x0, y0, z0, s1_0, s2_0, busy0, done0, eq0;
   logic [7:0] mt0, xt0, mm0;
   logic [3:0] ones0;
   logic       start1, x1, y1, z1, s1_1, s2_1, busy1, done1, eq1;
   logic [7:0] mt1, xt1, mm1;
   logic [3:0] ones1;

   logic [7:0] s1_tab, s2_tab;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] mt;
      logic [7:0] xt;
      logic [7:0] mm;
      logic [3:0] ones;
      logic       eq;
      int         done_at;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign s1_0 = s1_tab[{x0, y0, z0}];
   assign s2_0 = s2_tab[{x0, y0, z0}];
   assign s1_1 = 1'b0;
   assign s2_1 = 1'b0;

   truth_table_scanner u_dut (
      .clk(clk), .reset(reset), .start(start0),
      .x(x0), .y(y0), .z(z0), .s1(s1_0), .s2(s2_0),
      .busy(busy0), .done(done0),
      .minterms(mt0), .maxterms(xt0), .mismatch(mm0),
      .ones(ones0), .equal(eq0)
   );

   truth_table_scanner #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset), .start(start1),
      .x(x1), .y(y1), .z(z1), .s1(s1_1), .s2(s2_1),
      .busy(busy1), .done(done1),
      .minterms(mt1), .maxterms(xt1), .mismatch(mm1),
      .ones(ones1), .equal(eq1)
   );

   function automatic exp_t model(input logic [7:0] t1, input logic [7:0] t2, input int at);
      exp_t e;
      int   c;
      c = 0;
      for (int i = 0; i < 8; i++) if (t1[i]) c++;
      e.mt      = t1;
      e.xt      = ~t1;
      e.mm      = t1 ^ t2;
      e.ones    = 4'(c);
      e.eq      = (e.mm == 8'h00);
      e.done_at = at;
      return e;
   endfunction

   // Scan on the default instance; optional start re-pulses at rows 2, 7 and in DONE.
   task automatic scan0(input string name, input bit repulse);
      exp_t e;
      bit   got;
      int   t0, done_at, done_cnt;
      got = 0; done_at = -1; done_cnt = 0;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0; t0 = cyc;
      n_checks++;
      if ({busy0, ones0, eq0} !== {1'b1, 4'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL %s busy/ones/equal after start: got %b want 1_0000_0", name, {busy0, ones0, eq0});
      end
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (repulse) start0 = (k == 4 || k == 14 || k == 16);
         if (k == 8) begin
            n_checks++;
            if ({mt0, xt0, mm0} !== {s1_tab & 8'h0F, ~s1_tab & 8'h0F, (s1_tab ^ s2_tab) & 8'h0F}) begin
               n_fail++;
               $display("FAIL %s partial masks after row 3: got %h want %h", name,
                        {mt0, xt0, mm0}, {s1_tab & 8'h0F, ~s1_tab & 8'h0F, (s1_tab ^ s2_tab) & 8'h0F});
            end
         end
         if (done0 === 1'b1) begin
            done_cnt++;
            if (!got) begin
               got = 1; done_at = cyc - t0;
               e = sb.pop_front();
               n_checks++;
               if ({mt0, xt0, mm0, ones0, eq0} !== {e.mt, e.xt, e.mm, e.ones, e.eq}) begin
                  n_fail++;
                  $display("FAIL %s results at done: got mt=%b xt=%b mm=%b ones=%0d eq=%b want mt=%b xt=%b mm=%b ones=%0d eq=%b",
                           name, mt0, xt0, mm0, ones0, eq0, e.mt, e.xt, e.mm, e.ones, e.eq);
               end
            end
         end
      end
      start0 = 1'b0;
      if (!got) begin
         e = sb.pop_front();
         n_checks++; n_fail++;
         $display("FAIL %s done timeout: got no done within 40 cycles, want done at edge %0d", name, e.done_at);
      end else begin
         n_checks++;
         if (done_at != e.done_at) begin
            n_fail++;
            $display("FAIL %s done edge: got %0d want %0d", name, done_at, e.done_at);
         end
      end
      n_checks++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL %s done pulses: got %0d want 1", name, done_cnt);
      end
      n_checks++;
      if ({x0, y0, z0, busy0} !== 4'b0000) begin
         n_fail++;
         $display("FAIL %s idle xyz/busy: got %b want 0000", name, {x0, y0, z0, busy0});
      end
      n_checks++;
      if ({mt0, xt0, mm0, ones0, eq0} !== {e.mt, e.xt, e.mm, e.ones, e.eq}) begin
         n_fail++;
         $display("FAIL %s results held in idle: got %h want %h", name,
                  {mt0, xt0, mm0, ones0, eq0}, {e.mt, e.xt, e.mm, e.ones, e.eq});
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
      s1_tab = 8'h00; s2_tab = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({x0, y0, z0, busy0, done0, mt0, xt0, mm0, ones0, eq0} !== '0) begin
         n_fail++;
         $display("FAIL reset dut outputs: got %h want 0", {x0, y0, z0, busy0, done0, mt0, xt0, mm0, ones0, eq0});
      end
      n_checks++;
      if ({x1, y1, z1, busy1, done1, mt1, xt1, mm1, ones1, eq1} !== '0) begin
         n_fail++;
         $display("FAIL reset dut3 outputs: got %h want 0", {x1, y1, z1, busy1, done1, mt1, xt1, mm1, ones1, eq1});
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_sop_pos();
      s1_tab = 8'b11001011;                 // SoP minterms 0,1,3,6,7
      s2_tab = ~8'b00110100;                // PoS maxterms 2,4,5
      sb.push_back(model(s1_tab, s2_tab, 16));
      scan0("sop_pos", 1'b0);
      n_checks++;
      if ({mt0, xt0, ones0} !== {8'b11001011, 8'b00110100, 4'd5}) begin
         n_fail++;
         $display("FAIL sop_pos literal: got %b want 11001011_00110100_0101", {mt0, xt0, ones0});
      end
   endtask

   task automatic test_mismatch_row5();
      s1_tab = 8'b11001011;
      s2_tab = ~8'b00110100 ^ 8'b00100000;
      sb.push_back(model(s1_tab, s2_tab, 16));
      scan0("mismatch_row5", 1'b0);
      n_checks++;
      if ({mm0, eq0} !== {8'b00100000, 1'b0}) begin
         n_fail++;
         $display("FAIL mismatch_row5 literal: got %b want 00100000_0", {mm0, eq0});
      end
   endtask

   task automatic test_settle3();
      exp_t e;
      bit   got;
      int   t0, done_at;
      got = 0; done_at = -1;
      sb.push_back(model(8'h00, 8'h00, 32));
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0; t0 = cyc;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k % 4 == 2 && k < 32) begin
            n_checks++;
            if ({x1, y1, z1} !== 3'(k / 4)) begin
               n_fail++;
               $display("FAIL settle3 xyz at offset %0d: got %0d want %0d", k, {x1, y1, z1}, k / 4);
            end
         end
         if (done1 === 1'b1 && !got) begin
            got = 1; done_at = cyc - t0;
            e = sb.pop_front();
            n_checks++;
            if ({mt1, xt1, mm1, ones1, eq1} !== {e.mt, e.xt, e.mm, e.ones, e.eq}) begin
               n_fail++;
               $display("FAIL settle3 results: got mt=%h xt=%h mm=%h ones=%0d eq=%b want mt=%h xt=%h mm=%h ones=%0d eq=%b",
                        mt1, xt1, mm1, ones1, eq1, e.mt, e.xt, e.mm, e.ones, e.eq);
            end
         end
      end
      if (!got) begin
         e = sb.pop_front();
         n_checks++; n_fail++;
         $display("FAIL settle3 done timeout: got none within 60 cycles, want edge %0d", e.done_at);
      end else begin
         n_checks++;
         if (done_at != e.done_at) begin
            n_fail++;
            $display("FAIL settle3 done edge: got %0d want %0d", done_at, e.done_at);
         end
      end
   endtask

   task automatic test_reset_mid();
      s1_tab = 8'b10010110;
      s2_tab = 8'b10010111;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      repeat (6) @(negedge clk);
      n_checks++;
      if ({x0, y0, z0, busy0} !== 4'b0111) begin
         n_fail++;
         $display("FAIL reset_mid row 3 settling: got %b want 0111", {x0, y0, z0, busy0});
      end
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if ({x0, y0, z0, busy0, done0, mt0, xt0, mm0, ones0, eq0} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid outputs: got %h want 0", {x0, y0, z0, busy0, done0, mt0, xt0, mm0, ones0, eq0});
      end
      @(negedge clk); reset = 1'b0;
      sb.push_back(model(s1_tab, s2_tab, 16));
      scan0("after_reset", 1'b0);
   endtask

   task automatic test_ignored_start();
      s1_tab = 8'b01100101;
      s2_tab = 8'b01100101;
      sb.push_back(model(s1_tab, s2_tab, 16));
      scan0("ignored_start", 1'b1);
   endtask

   initial begin
      test_reset();
      test_sop_pos();
      test_mismatch_row5();
      test_settle3();
      test_reset_mid();
      test_ignored_start();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
